// File: rtl/brick_game_pkg.sv
// Shared types and constants for the brick breaker game sequencer.
package brick_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } state_e;

  localparam int NUM_BRICKS_DEFAULT = 6;
  localparam int LIVES_DEFAULT      = 3;
  localparam int BRICK_IDX_W        = 3;

endpackage

// File: rtl/brick_game_ctrl_serve_timer.sv
// Loadable frame-tick down-counter; done is high while the count is zero.
module serve_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/brick_game_ctrl.sv
// Brick breaker game sequencer: state machine, brick/score/lives bookkeeping
// and the per-frame ball and paddle step pulses.
module brick_game_ctrl
  import brick_game_pkg::*;
#(
  parameter int NUM_BRICKS   = NUM_BRICKS_DEFAULT,
  parameter int LIVES        = LIVES_DEFAULT,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   left,
  input  logic                   right,
  input  logic                   frame_tick,
  input  logic                   brick_hit,
  input  logic [BRICK_IDX_W-1:0] brick_idx,
  input  logic                   ball_missed,
  output logic [2:0]             state,
  output logic [NUM_BRICKS-1:0]  bricks_exist,
  output logic [1:0]             lives,
  output logic [SCORE_W-1:0]     score,
  output logic                   ball_reset,
  output logic                   ball_step,
  output logic                   paddle_left,
  output logic                   paddle_right,
  output logic                   game_over,
  output logic                   victory
);

  localparam int              CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                 state_q, state_d;
  logic                   start_q;
  logic [NUM_BRICKS-1:0]  bricks_q, bricks_d;
  logic [1:0]             lives_q, lives_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic                   ball_step_q, paddle_left_q, paddle_right_q;

  logic                   start_rise;
  logic                   in_play, in_move;
  logic [NUM_BRICKS-1:0]  hit_mask;
  logic                   idx_ok;
  logic                   hit_valid;
  logic                   timer_load;
  logic                   timer_done;

  assign start_rise = start & ~start_q;
  assign in_play    = (state_q == PLAY);
  assign in_move    = (state_q == SERVE) || (state_q == PLAY);
  // Out-of-range indices shift the bit off the top, leaving an empty mask.
  assign hit_mask   = NUM_BRICKS'(1) << brick_idx;
  assign idx_ok     = int'(brick_idx) < NUM_BRICKS;
  assign hit_valid  = brick_hit && in_play && idx_ok && (|(hit_mask & bricks_q));

  serve_timer #(
    .CNT_W(CNT_W)
  ) u_serve_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(SERVE_LOAD),
    .tick    (frame_tick && (state_q == SERVE)),
    .done    (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    bricks_d   = bricks_q;
    lives_d    = lives_q;
    score_d    = score_q;
    timer_load = 1'b0;

    if (hit_valid) begin
      bricks_d = bricks_q & ~hit_mask;
      score_d  = sat_inc(score_q);
    end

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d    = SERVE;
          timer_load = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick && timer_done) state_d = PLAY;
      end
      PLAY: begin
        // A miss that coincides with clearing the last brick stays in PLAY so
        // the empty-field check promotes it to WIN on the next clock.
        if (bricks_q == '0) begin
          state_d = WIN;
        end else if (ball_missed && (bricks_d != '0)) begin
          state_d = MISS;
        end
      end
      MISS: begin
        lives_d = lives_q - 2'd1;
        if (lives_q == 2'd1) begin
          state_d = OVER;
        end else begin
          state_d    = SERVE;
          timer_load = 1'b1;
        end
      end
      OVER, WIN: begin
        if (start_rise) begin
          state_d    = SERVE;
          timer_load = 1'b1;
          bricks_d   = '1;
          lives_d    = LIVES_INIT;
          score_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      bricks_q       <= '1;
      lives_q        <= LIVES_INIT;
      score_q        <= '0;
      ball_step_q    <= 1'b0;
      paddle_left_q  <= 1'b0;
      paddle_right_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start;
      bricks_q       <= bricks_d;
      lives_q        <= lives_d;
      score_q        <= score_d;
      ball_step_q    <= frame_tick && in_play;
      paddle_left_q  <= frame_tick && in_move && left && !right;
      paddle_right_q <= frame_tick && in_move && right && !left;
    end
  end

  assign state        = state_q;
  assign bricks_exist = bricks_q;
  assign lives        = lives_q;
  assign score        = score_q;
  assign ball_reset   = (state_q != PLAY);
  assign ball_step    = ball_step_q;
  assign paddle_left  = paddle_left_q;
  assign paddle_right = paddle_right_q;
  assign game_over    = (state_q == OVER);
  assign victory      = (state_q == WIN);

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Bench for brick_game_ctrl: scenario tasks plus a pulse scoreboard that
// pairs every frame_tick with the {ball_step, paddle_left, paddle_right} it should produce.
module tb_brick_game_ctrl;
  import brick_game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, left = 1'b0, right = 1'b0;
  logic       frame_tick = 1'b0, brick_hit = 1'b0, ball_missed = 1'b0;
  logic [2:0] brick_idx = 3'd0;

  logic [2:0] state;
  logic [5:0] bricks_exist;
  logic [1:0] lives;
  logic [7:0] score;
  logic       ball_reset, ball_step, paddle_left, paddle_right, game_over, victory;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       tick_seen;
  logic [2:0] pulses, exp_p;

  brick_game_ctrl #(
    .NUM_BRICKS(6), .LIVES(3), .SERVE_FRAMES(2), .SCORE_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .left(left), .right(right),
    .frame_tick(frame_tick), .brick_hit(brick_hit), .brick_idx(brick_idx),
    .ball_missed(ball_missed), .state(state), .bricks_exist(bricks_exist),
    .lives(lives), .score(score), .ball_reset(ball_reset), .ball_step(ball_step),
    .paddle_left(paddle_left), .paddle_right(paddle_right),
    .game_over(game_over), .victory(victory)
  );

  always #5 clk = ~clk;

  // {state, bricks, lives, score, ball_reset, game_over, victory}
  function automatic logic [21:0] snap();
    return {state, bricks_exist, lives, score, ball_reset, game_over, victory};
  endfunction

  // Scoreboard: each frame_tick seen at an edge pops one expected pulse vector;
  // with no tick, all pulses must be low.
  always @(posedge clk) begin
    if (mon_en) begin
      tick_seen = frame_tick;
      #1;
      pulses = {ball_step, paddle_left, paddle_right};
      n_checks++;
      if (tick_seen) begin
        if (exp_q.size() == 0) begin
          $display("FAIL sb_underflow got pulses %b with no expectation queued", pulses);
        end else begin
          exp_p = exp_q.pop_front();
          if (pulses !== exp_p) $display("FAIL sb_pulses t=%0t got %b exp %b", $time, pulses, exp_p);
          else n_pass++;
        end
      end else begin
        if (pulses !== 3'b000) $display("FAIL sb_spurious t=%0t got %b exp 000", $time, pulses);
        else n_pass++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input logic [2:0] e);
    exp_q.push_back(e);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic hit(input logic [2:0] idx);
    brick_hit = 1'b1;
    brick_idx = idx;
    cyc(1);
    brick_hit = 1'b0;
  endtask

  task automatic miss();
    ball_missed = 1'b1;
    cyc(1);
    ball_missed = 1'b0;
  endtask

  task automatic hit_miss(input logic [2:0] idx);
    brick_hit   = 1'b1;
    brick_idx   = idx;
    ball_missed = 1'b1;
    cyc(1);
    brick_hit   = 1'b0;
    ball_missed = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  task automatic launch();
    tick(3'b000);
    tick(3'b000);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    mon_en = 1'b1;
    cyc(2);
    n_checks++;
    if (snap() !== {IDLE, 6'h3f, 2'd3, 8'd0, 3'b100})
      $display("FAIL reset_hold got %h exp %h", snap(), {IDLE, 6'h3f, 2'd3, 8'd0, 3'b100});
    else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      n_checks++;
      if (snap() !== {IDLE, 6'h3f, 2'd3, 8'd0, 3'b100})
        $display("FAIL idle_cycle%0d got %h exp %h", i, snap(), {IDLE, 6'h3f, 2'd3, 8'd0, 3'b100});
      else n_pass++;
    end
  endtask

  task automatic test_serve();
    start = 1'b1;
    cyc(1);
    n_checks++;
    if (snap() !== {SERVE, 6'h3f, 2'd3, 8'd0, 3'b100})
      $display("FAIL serve_entry got %h exp %h", snap(), {SERVE, 6'h3f, 2'd3, 8'd0, 3'b100});
    else n_pass++;
    cyc(2);
    tick(3'b000);
    n_checks++;
    if (state !== SERVE) $display("FAIL serve_tick1 got state %0d exp %0d", state, SERVE);
    else n_pass++;
    cyc(2);
    tick(3'b000);
    n_checks++;
    if (snap() !== {PLAY, 6'h3f, 2'd3, 8'd0, 3'b000})
      $display("FAIL serve_launch got %h exp %h", snap(), {PLAY, 6'h3f, 2'd3, 8'd0, 3'b000});
    else n_pass++;
    cyc(3);
    start = 1'b0;
    tick(3'b100);
    cyc(2);
    tick(3'b100);
    n_checks++;
    if (state !== PLAY) $display("FAIL play_hold got state %0d exp %0d", state, PLAY);
    else n_pass++;
  endtask

  task automatic test_clear_bricks();
    hit(3'd0);
    n_checks++;
    if ({bricks_exist, score} !== {6'b111110, 8'd1})
      $display("FAIL hit0 got %b/%0d exp 111110/1", bricks_exist, score);
    else n_pass++;
    hit(3'd1);
    hit(3'd2);
    hit(3'd2);
    hit(3'd7);
    n_checks++;
    if ({bricks_exist, score} !== {6'b111000, 8'd3})
      $display("FAIL dup_oob got %b/%0d exp 111000/3", bricks_exist, score);
    else n_pass++;
    hit(3'd3);
    hit(3'd4);
    start = 1'b1;
    cyc(1);
    n_checks++;
    if ({state, bricks_exist, score} !== {PLAY, 6'b100000, 8'd5})
      $display("FAIL five_cleared got %0d/%b/%0d exp 2/100000/5", state, bricks_exist, score);
    else n_pass++;
    hit(3'd5);
    n_checks++;
    if ({bricks_exist, score} !== {6'b000000, 8'd6})
      $display("FAIL last_hit got %b/%0d exp 000000/6", bricks_exist, score);
    else n_pass++;
    for (int i = 0; i < 4 && state !== WIN; i++) cyc(1);
    n_checks++;
    if (snap() !== {WIN, 6'h00, 2'd3, 8'd6, 3'b101})
      $display("FAIL win got %h exp %h", snap(), {WIN, 6'h00, 2'd3, 8'd6, 3'b101});
    else n_pass++;
    cyc(3);
    n_checks++;
    if (state !== WIN) $display("FAIL win_held_start got state %0d exp %0d", state, WIN);
    else n_pass++;
    start = 1'b0;
    cyc(1);
    press_start();
    n_checks++;
    if (snap() !== {SERVE, 6'h3f, 2'd3, 8'd0, 3'b100})
      $display("FAIL restart_win got %h exp %h", snap(), {SERVE, 6'h3f, 2'd3, 8'd0, 3'b100});
    else n_pass++;
  endtask

  task automatic test_lose_game();
    miss();
    n_checks++;
    if ({state, lives} !== {SERVE, 2'd3})
      $display("FAIL miss_in_serve got %0d/%0d exp 1/3", state, lives);
    else n_pass++;
    launch();
    for (int k = 1; k <= 3; k++) begin
      miss();
      n_checks++;
      if ({state, lives} !== {MISS, 2'(4 - k)})
        $display("FAIL miss%0d got %0d/%0d exp 3/%0d", k, state, lives, 4 - k);
      else n_pass++;
      cyc(1);
      if (k < 3) begin
        n_checks++;
        if ({state, lives} !== {SERVE, 2'(3 - k)})
          $display("FAIL reserve%0d got %0d/%0d exp 1/%0d", k, state, lives, 3 - k);
        else n_pass++;
        launch();
      end
    end
    n_checks++;
    if (snap() !== {OVER, 6'h3f, 2'd0, 8'd0, 3'b110})
      $display("FAIL over got %h exp %h", snap(), {OVER, 6'h3f, 2'd0, 8'd0, 3'b110});
    else n_pass++;
    hit(3'd0);
    miss();
    n_checks++;
    if (snap() !== {OVER, 6'h3f, 2'd0, 8'd0, 3'b110})
      $display("FAIL over_ignores got %h exp %h", snap(), {OVER, 6'h3f, 2'd0, 8'd0, 3'b110});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    press_start();
    n_checks++;
    if ({state, lives} !== {SERVE, 2'd3}) $display("FAIL restart_over got %0d/%0d exp 1/3", state, lives);
    else n_pass++;
    launch();
    press_start();
    n_checks++;
    if (state !== PLAY) $display("FAIL start_in_play got state %0d exp %0d", state, PLAY);
    else n_pass++;
    for (int i = 0; i < 4; i++) hit(3'(i));
    hit_miss(3'd4);
    n_checks++;
    if ({state, bricks_exist, score} !== {MISS, 6'b100000, 8'd5})
      $display("FAIL hit_miss4 got %0d/%b/%0d exp 3/100000/5", state, bricks_exist, score);
    else n_pass++;
    cyc(1);
    n_checks++;
    if ({state, lives} !== {SERVE, 2'd2}) $display("FAIL hit_miss4_serve got %0d/%0d exp 1/2", state, lives);
    else n_pass++;
    launch();
    hit_miss(3'd5);
    for (int i = 0; i < 4 && state !== WIN; i++) cyc(1);
    n_checks++;
    if (snap() !== {WIN, 6'h00, 2'd2, 8'd6, 3'b101})
      $display("FAIL hit_miss_win got %h exp %h", snap(), {WIN, 6'h00, 2'd2, 8'd6, 3'b101});
    else n_pass++;
  endtask

  task automatic test_paddle_reset();
    press_start();
    left = 1'b1;
    tick(3'b010);
    right = 1'b1;
    tick(3'b000);
    n_checks++;
    if (state !== PLAY) $display("FAIL paddle_launch got state %0d exp %0d", state, PLAY);
    else n_pass++;
    left = 1'b0;
    tick(3'b101);
    right = 1'b0;
    tick(3'b100);
    left = 1'b1;
    tick(3'b110);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({ball_step, paddle_left, paddle_right} !== 3'b000)
      $display("FAIL reset_abort_pulses got %b exp 000", {ball_step, paddle_left, paddle_right});
    else n_pass++;
    n_checks++;
    if (snap() !== {IDLE, 6'h3f, 2'd3, 8'd0, 3'b100})
      $display("FAIL reset_abort got %h exp %h", snap(), {IDLE, 6'h3f, 2'd3, 8'd0, 3'b100});
    else n_pass++;
    tick(3'b000);
    cyc(2);
    rst  = 1'b1;
    left = 1'b0;
    tick(3'b000);
    cyc(3);
    n_checks++;
    if (snap() !== {IDLE, 6'h3f, 2'd3, 8'd0, 3'b100})
      $display("FAIL post_reset got %h exp %h", snap(), {IDLE, 6'h3f, 2'd3, 8'd0, 3'b100});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_clear_bricks();
    test_lose_game();
    test_simultaneous();
    test_paddle_reset();
    cyc(2);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d entries exp 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/brick_game_ctrl.md
Name: brick_game_ctrl

Overview:
Game sequencer for the brick breaker top level. It takes per-frame ticks from the VGA timing, the player buttons, and collision events from the ball/brick datapath. It runs the game state machine and drives game_over, victory and bricks_exist. It also generates the per-frame enables that move the paddle and ball.

Parameters:
NUM_BRICKS, 6, number of bricks; width of bricks_exist.
LIVES, 3, balls per game; must be 1..3.
SERVE_FRAMES, 60, frames the ball is held on the paddle before launch; must be >= 1.
SCORE_W, 8, score width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  start/restart button, level; rising edge used
left  in  1  move-left button, level
right  in  1  move-right button, level
frame_tick  in  1  one-cycle pulse per frame (end of active video)
brick_hit  in  1  one-cycle pulse: ball collided with brick brick_idx
brick_idx  in  3  index of hit brick
ball_missed  in  1  one-cycle pulse: ball passed below paddle
state  out  3  current state encoding (package enum)
bricks_exist  out  NUM_BRICKS  1 = brick present
lives  out  2  remaining lives
score  out  SCORE_W  bricks destroyed this game
ball_reset  out  1  hold ball on paddle (level)
ball_step  out  1  one-cycle pulse: advance ball one frame
paddle_left  out  1  one-cycle pulse: move paddle left one step
paddle_right  out  1  one-cycle pulse: move paddle right one step
game_over  out  1  level, high in OVER
victory  out  1  level, high in WIN

Behaviour:
- Reset (rst=0, async): state=IDLE, bricks_exist=all 1, lives=LIVES, score=0, serve counter=0. ball_reset=1; ball_step, paddle_left, paddle_right, game_over and victory are 0. Reset mid-game aborts immediately, with no pending pulses.
- start_rise = start & ~start_q, where start_q is a registered copy of start (reset 0). Holding start produces exactly one event.
- States: IDLE, SERVE, PLAY, MISS, OVER, WIN.
- IDLE -> SERVE on start_rise. Counter loads SERVE_FRAMES-1.
- SERVE:
  - ball_reset=1.
  - On frame_tick: if counter==0 -> PLAY, else decrement.
  - brick_hit and ball_missed are ignored.
- PLAY:
  - ball_reset=0.
  - ball_step is a registered copy of frame_tick, so it pulses 1 cycle after each tick.
- brick_hit is valid only in PLAY, with brick_idx < NUM_BRICKS and bricks_exist[brick_idx]=1. A valid hit clears that bit and increments score, saturating at all-ones. Any other hit is ignored.
- Victory check: if the registered bricks_exist becomes zero -> WIN on the next clock.
- ball_missed in PLAY -> MISS.
- brick_hit and ball_missed in the same cycle: the hit is applied. If it clears the last brick -> WIN (victory wins). Otherwise -> MISS.
- MISS: lasts one cycle; lives decrements.
  - If lives was 1 (reaches 0) -> OVER.
  - Otherwise -> SERVE, with the counter reloaded to SERVE_FRAMES-1.
- OVER: game_over=1, ball_reset=1.
- WIN: victory=1, ball_reset=1.
- Restart: start_rise in OVER or WIN reinitialises bricks_exist, lives and score to their reset values and goes to SERVE. start_rise in SERVE/PLAY/MISS is ignored.
- Paddle: only in SERVE and PLAY, on frame_tick:
  - paddle_left pulses when left & ~right.
  - paddle_right pulses when right & ~left.
  - Both pulses are registered, 1 cycle after the tick.
  - Both buttons or neither -> no pulse. No pulses in other states.
- All outputs are registered or decoded from registered state; no input-to-output combinational paths.

Decomposition:
- brick_game_pkg holds:
  - the state enum (IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, WIN=5);
  - NUM_BRICKS_DEFAULT, LIVES_DEFAULT;
  - the brick_idx width constant.
- One sub-module, serve_timer: a loadable frame-tick down-counter with a done flag. The edge detector stays inline.

Test Plan:
- Reset/idle: hold rst=0 then release with no start -> state=IDLE, bricks_exist=6'b111111, lives=3, score=0, ball_reset=1, all pulses 0 for 100 cycles.
- Serve/launch: SERVE_FRAMES=2, start held high for 10 cycles -> one SERVE entry. PLAY is reached on the 2nd frame_tick. A ball_step pulse follows each later tick by 1 cycle.
- Clear all bricks: in PLAY, hits on idx 0..5, plus a duplicate hit on idx 2 and a hit on idx 7 -> score=6 (duplicates/out-of-range ignored), bricks_exist=0, then WIN with victory=1. A subsequent start_rise restores 6'b111111, lives=3, score=0, state=SERVE.
- Lose game: 3 ball_missed pulses, each in PLAY after its serve -> lives 3->2->1->0, SERVE re-entered twice, then OVER with game_over=1. Later brick_hit is ignored.
- Simultaneous events: with 5 bricks cleared, brick_hit(idx of last) and ball_missed in the same cycle -> WIN, lives unchanged. With 4 cleared -> score increments, then MISS -> SERVE, lives decremented.
- Paddle and reset: left=1 -> paddle_left pulse per tick; left=right=1 -> none. Asserting rst=0 mid-PLAY -> immediate IDLE and reset values, no further pulses.
